// File: rtl/vga_line_output.sv
// VGA line-buffered scan-out: two line banks plus a phase-accumulator pixel strobe.
// Optional VGA_TEST_PATTERN_EN adds a test_mode input that shows 8 colour bars.
module vga_line_output #(
  parameter int          H_ACTIVE = 1024,
  parameter int          H_FP     = 24,
  parameter int          H_SYNC   = 136,
  parameter int          H_BP     = 160,
  parameter int          V_ACTIVE = 768,
  parameter int          V_FP     = 3,
  parameter int          V_SYNC   = 6,
  parameter int          V_BP     = 29,
  parameter logic        HS_POL   = 1'b0,
  parameter logic        VS_POL   = 1'b0,
  parameter int          CBITS    = 4,
  parameter logic [15:0] PIX_INC  = 16'hA666,
  parameter int          XW       = 11
) (
  input  logic               CLK,
  input  logic               RST_N,
  input  logic               wr_en,
  input  logic [XW-1:0]      wr_x,
  input  logic [3*CBITS-1:0] wr_data,
  input  logic               wr_swap,
`ifdef VGA_TEST_PATTERN_EN
  input  logic               test_mode,
`endif
  output logic               VGA_HS_OUT,
  output logic               VGA_VS_OUT,
  output logic [CBITS-1:0]   VGA_R,
  output logic [CBITS-1:0]   VGA_G,
  output logic [CBITS-1:0]   VGA_B,
  output logic               VGA_LINEEND_OUT,
  output logic               line_req,
  output logic               frame_start,
  output logic               underrun
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int VW = (V_TOTAL > 1) ? $clog2(V_TOTAL) : 1;
  localparam int AW = (H_ACTIVE > 1) ? $clog2(H_ACTIVE) : 1;
  localparam int PW = 3 * CBITS;

  localparam logic [XW-1:0] H_ACT   = XW'(H_ACTIVE);
  localparam logic [XW-1:0] H_LE    = XW'(H_ACTIVE - 1);
  localparam logic [XW-1:0] H_FP_E  = XW'(H_ACTIVE + H_FP);
  localparam logic [XW-1:0] H_SY_E  = XW'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [XW-1:0] H_LAST  = XW'(H_TOTAL - 1);
  localparam logic [VW-1:0] V_ACT   = VW'(V_ACTIVE);
  localparam logic [VW-1:0] V_SY_S  = VW'(V_ACTIVE + V_FP);
  localparam logic [VW-1:0] V_SY_E  = VW'(V_ACTIVE + V_FP + V_SYNC);
  localparam logic [VW-1:0] V_LAST  = VW'(V_TOTAL - 1);

  logic [15:0]   acc;
  logic [16:0]   acc_sum;
  logic          pix_stb;

  logic [XW-1:0] h_q;
  logic [VW-1:0] v_q;
  logic [XW-1:0] h_nxt;
  logic [VW-1:0] v_nxt;

  logic          front;
  logic          pending;
  logic          pending_nxt;
  logic          under_q;
  logic          line_end;
  logic          swap_req;
  logic          swap_now;
  logic          under_set;
  logic          tp_on;

  logic          active;
  logic          hs_zone;
  logic          vs_zone;
  logic          le_zone;

  logic [PW-1:0] mem [2][H_ACTIVE];
  logic [PW-1:0] rd_data;
  logic [PW-1:0] pix_rgb;
  logic          wr_ok;
  logic [AW-1:0] wr_a;

  logic [PW-1:0] rgb_q;
  logic          hs_q;
  logic          vs_q;
  logic          le_q;
  logic          lreq_q;
  logic          fs_q;

  always_comb begin
    acc_sum = {1'b0, acc} + {1'b0, PIX_INC};
    pix_stb = acc_sum[16];
  end

  always_comb begin
    h_nxt = h_q + 1'b1;
    v_nxt = v_q;
    if (h_q == H_LAST) begin
      h_nxt = '0;
      v_nxt = (v_q == V_LAST) ? '0 : v_q + 1'b1;
    end
  end

  always_comb begin
    active  = (h_q < H_ACT) && (v_q < V_ACT);
    le_zone = (h_q >= H_ACT) && (h_q < H_FP_E);
    hs_zone = (h_q >= H_FP_E) && (h_q < H_SY_E);
    vs_zone = (v_q >= V_SY_S) && (v_q < V_SY_E);
  end

`ifdef VGA_TEST_PATTERN_EN
  logic [XW+2:0] hx8;
  logic [2:0]    bar;
  logic [PW-1:0] bar_rgb;

  always_comb begin
    tp_on   = test_mode;
    hx8     = {h_q, 3'b000};
    bar     = 3'(hx8 / (XW+3)'(H_ACTIVE));
    bar_rgb = {{CBITS{bar[0]}}, {CBITS{bar[1]}}, {CBITS{bar[2]}}};
  end
`else
  always_comb tp_on = 1'b0;
`endif

  // A swap request arriving on the line-end clock itself still counts.
  always_comb begin
    line_end  = pix_stb && (h_q == H_LE);
    swap_req  = pending || wr_swap;
    swap_now  = line_end && swap_req;
    under_set = line_end && !swap_req && !tp_on;
    pending_nxt = pending;
    if (swap_now) begin
      pending_nxt = 1'b0;
    end else if (wr_swap) begin
      pending_nxt = 1'b1;
    end
  end

  always_comb begin
    wr_ok   = wr_en && (wr_x < H_ACT);
    wr_a    = wr_x[AW-1:0];
    rd_data = mem[front][h_q[AW-1:0]];
  end

  always_comb begin
    pix_rgb = '0;
`ifdef VGA_TEST_PATTERN_EN
    if (active && tp_on) begin
      pix_rgb = bar_rgb;
    end else if (active) begin
      pix_rgb = rd_data;
    end
`else
    if (active) begin
      pix_rgb = rd_data;
    end
`endif
  end

  // Writes use the bank that is "back" before any same-edge exchange.
  always_ff @(posedge CLK) begin
    if (wr_ok) begin
      mem[~front][wr_a] <= wr_data;
    end
  end

  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      acc     <= '0;
      h_q     <= '0;
      v_q     <= '0;
      front   <= 1'b0;
      pending <= 1'b0;
      under_q <= 1'b0;
      rgb_q   <= '0;
      hs_q    <= ~HS_POL;
      vs_q    <= ~VS_POL;
      le_q    <= 1'b0;
      lreq_q  <= 1'b0;
      fs_q    <= 1'b0;
    end else begin
      acc     <= acc_sum[15:0];
      pending <= pending_nxt;
      lreq_q  <= swap_now;
      fs_q    <= pix_stb && (h_q == '0) && (v_q == '0);
      if (swap_now) begin
        front <= ~front;
      end
      if (under_set) begin
        under_q <= 1'b1;
      end
      if (pix_stb) begin
        h_q   <= h_nxt;
        v_q   <= v_nxt;
        rgb_q <= pix_rgb;
        hs_q  <= hs_zone ? HS_POL : ~HS_POL;
        vs_q  <= vs_zone ? VS_POL : ~VS_POL;
        le_q  <= le_zone;
      end
    end
  end

  always_comb begin
    VGA_R           = rgb_q[PW-1:2*CBITS];
    VGA_G           = rgb_q[2*CBITS-1:CBITS];
    VGA_B           = rgb_q[CBITS-1:0];
    VGA_HS_OUT      = hs_q;
    VGA_VS_OUT      = vs_q;
    VGA_LINEEND_OUT = le_q;
    line_req        = lreq_q;
    frame_start     = fs_q;
    underrun        = under_q;
  end

endmodule

// File: tb/tb_vga_line_output.sv
// Directed bench for vga_line_output on a small 24x8 raster, strobe every 2nd CLK.
// Pixel n (n = v*24 + h) is on the outputs at negedge count 2n+2 after reset release.
module tb_vga_line_output;

  logic        CLK = 1'b0;
  logic        RST_N;
  logic        wr_en;
  logic [10:0] wr_x;
  logic [11:0] wr_data;
  logic        wr_swap;
`ifdef VGA_TEST_PATTERN_EN
  logic        test_mode;
`endif
  logic        hs;
  logic        vs;
  logic [3:0]  r;
  logic [3:0]  g;
  logic [3:0]  b;
  logic        lineend;
  logic        line_req;
  logic        frame_start;
  logic        underrun;

  int vectors = 0;
  int errors  = 0;
  int cyc     = 0;

  vga_line_output #(
    .H_ACTIVE(16), .H_FP(2), .H_SYNC(3), .H_BP(3),
    .V_ACTIVE(4), .V_FP(1), .V_SYNC(2), .V_BP(1),
    .HS_POL(1'b0), .VS_POL(1'b0), .CBITS(4),
    .PIX_INC(16'h8000), .XW(11)
  ) dut (
    .CLK(CLK),
    .RST_N(RST_N),
    .wr_en(wr_en),
    .wr_x(wr_x),
    .wr_data(wr_data),
    .wr_swap(wr_swap),
`ifdef VGA_TEST_PATTERN_EN
    .test_mode(test_mode),
`endif
    .VGA_HS_OUT(hs),
    .VGA_VS_OUT(vs),
    .VGA_R(r),
    .VGA_G(g),
    .VGA_B(b),
    .VGA_LINEEND_OUT(lineend),
    .line_req(line_req),
    .frame_start(frame_start),
    .underrun(underrun)
  );

  always #5 CLK = ~CLK;

  function automatic logic [11:0] fa(input logic [3:0] x);
    return {x, ~x, x ^ 4'h5};
  endfunction

  function automatic logic [11:0] fb(input logic [3:0] x);
    return {4'h3, x ^ 4'hA, x};
  endfunction

  task automatic wait_cyc(input int k);
    while (cyc < k) begin
      @(negedge CLK);
      cyc++;
    end
  endtask

  task automatic chk(input string tag, input logic [15:0] got,
                     input logic [15:0] exp);
    vectors++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: got %h, expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [15:0] rgb();
    return {4'h0, r, g, b};
  endfunction

  initial begin
    RST_N   = 1'b0;
    wr_en   = 1'b0;
    wr_x    = '0;
    wr_data = '0;
    wr_swap = 1'b0;
`ifdef VGA_TEST_PATTERN_EN
    test_mode = 1'b0;
`endif
    repeat (3) @(negedge CLK);
    chk("rst_rgb", rgb(), 16'h0);
    chk("rst_hs", 16'(hs), 16'h1);
    chk("rst_vs", 16'(vs), 16'h1);
    chk("rst_le", 16'(lineend), 16'h0);
    chk("rst_lreq", 16'(line_req), 16'h0);
    chk("rst_fs", 16'(frame_start), 16'h0);
    chk("rst_und", 16'(underrun), 16'h0);
    RST_N = 1'b1;
    cyc   = 0;

    wait_cyc(1);
    chk("fs_c1", 16'(frame_start), 16'h0);
    wait_cyc(2);
    chk("fs_c2", 16'(frame_start), 16'h1);
    chk("hs_h0", 16'(hs), 16'h1);
    wait_cyc(3);
    chk("fs_c3", 16'(frame_start), 16'h0);

    wait_cyc(4);
    for (int x = 0; x < 16; x++) begin
      wr_en   = 1'b1;
      wr_x    = 11'(x);
      wr_data = fa(4'(x));
      wait_cyc(cyc + 1);
    end
    wr_en   = 1'b0;
    wr_swap = 1'b1;
    wait_cyc(cyc + 1);
    wr_swap = 1'b0;

    wait_cyc(31);
    chk("lreq_c31", 16'(line_req), 16'h0);
    wait_cyc(32);
    chk("lreq_c32", 16'(line_req), 16'h1);
    chk("und_c32", 16'(underrun), 16'h0);
    wait_cyc(33);
    chk("lreq_c33", 16'(line_req), 16'h0);

    wait_cyc(34);
    for (int x = 0; x < 16; x++) begin
      wr_en   = 1'b1;
      wr_x    = 11'(x);
      wr_data = fb(4'(x));
      wait_cyc(cyc + 1);
    end
    chk("l1_px0", rgb(), 16'h00F5);
    wr_x    = 11'd1500;
    wr_data = 12'h777;
    wait_cyc(51);
    chk("l1_px0_hold", rgb(), 16'h00F5);
    wr_x    = 11'd16;
    wait_cyc(52);
    chk("l1_px1", rgb(), 16'h01E4);
    wr_x    = 11'd5;
    wr_data = 12'hF0F;
    wr_swap = 1'b1;
    wait_cyc(53);
    wr_en   = 1'b0;
    wr_swap = 1'b0;

    wait_cyc(64);
    chk("l1_px7", rgb(), 16'h0782);
    wait_cyc(80);
    chk("l1_px15", rgb(), 16'h0F0A);
    chk("lreq_c80", 16'(line_req), 16'h1);
    wait_cyc(82);
    chk("h16_rgb", rgb(), 16'h0);
    chk("h16_le", 16'(lineend), 16'h1);
    chk("h16_hs", 16'(hs), 16'h1);
    wait_cyc(84);
    chk("h17_le", 16'(lineend), 16'h1);
    wait_cyc(86);
    chk("h18_le", 16'(lineend), 16'h0);
    chk("h18_hs", 16'(hs), 16'h0);
    wait_cyc(90);
    chk("h20_hs", 16'(hs), 16'h0);
    wait_cyc(92);
    chk("h21_hs", 16'(hs), 16'h1);

    wait_cyc(98);
    chk("l2_px0", rgb(), 16'h03A0);
    wait_cyc(108);
    chk("l2_px5", rgb(), 16'h0F0F);
    wait_cyc(122);
    chk("l2_px12", rgb(), 16'h036C);
    wait_cyc(126);
    chk("und_c126", 16'(underrun), 16'h0);
    wait_cyc(128);
    chk("und_c128", 16'(underrun), 16'h1);
    chk("lreq_c128", 16'(line_req), 16'h0);
    wait_cyc(146);
    chk("l3_px0", rgb(), 16'h03A0);
    wait_cyc(156);
    chk("l3_px5", rgb(), 16'h0F0F);
    wait_cyc(194);
    chk("v4_rgb", rgb(), 16'h0);
    wait_cyc(240);
    chk("v4_vs", 16'(vs), 16'h1);
    wait_cyc(242);
    chk("v5_vs", 16'(vs), 16'h0);
    wait_cyc(290);
    chk("v6_vs", 16'(vs), 16'h0);
    wait_cyc(338);
    chk("v7_vs", 16'(vs), 16'h1);
    wait_cyc(385);
    chk("fs_c385", 16'(frame_start), 16'h0);
    wait_cyc(386);
    chk("fs_c386", 16'(frame_start), 16'h1);
    chk("und_c386", 16'(underrun), 16'h1);
    wait_cyc(387);
    chk("fs_c387", 16'(frame_start), 16'h0);

    wait_cyc(452);
    RST_N = 1'b0;
    wait_cyc(453);
    chk("mid_rgb", rgb(), 16'h0);
    chk("mid_hs", 16'(hs), 16'h1);
    chk("mid_vs", 16'(vs), 16'h1);
    chk("mid_le", 16'(lineend), 16'h0);
    chk("mid_lreq", 16'(line_req), 16'h0);
    chk("mid_fs", 16'(frame_start), 16'h0);
    chk("mid_und", 16'(underrun), 16'h0);
    RST_N = 1'b1;
    cyc   = 0;

    wait_cyc(1);
    chk("r2_fs_c1", 16'(frame_start), 16'h0);
    wait_cyc(2);
    chk("r2_fs_c2", 16'(frame_start), 16'h1);
    chk("r2_px0", rgb(), 16'h03A0);
    wait_cyc(12);
    chk("r2_px5", rgb(), 16'h0F0F);
`ifdef VGA_TEST_PATTERN_EN
    test_mode = 1'b1;
    wait_cyc(32);
    chk("tp_px15", rgb(), 16'h0FFF);
    wait_cyc(34);
    chk("tp_und", 16'(underrun), 16'h0);
    wait_cyc(50);
    chk("tp_px0", rgb(), 16'h0);
`else
    wait_cyc(30);
    chk("r2_und_c30", 16'(underrun), 16'h0);
    wait_cyc(32);
    chk("r2_und_c32", 16'(underrun), 16'h1);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
